// File: rtl/sum_prod_pkg.sv
// rtl/sum_prod_pkg.sv - shared types, defaults and width helper for sum_prod_seq
//
// Optional build macro: SUM_PROD_SEQ_PIPE_EN (adds the MUL state).

package sum_prod_pkg;

`ifdef SUM_PROD_SEQ_PIPE_EN
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        MUL    = 2'd2,
        DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        DONE   = 2'd3
    } state_t;
`endif

    localparam int NUM_PAIRS_DEF = 3;

    // Result width for three pair products of n-bit operands: 2n bits per
    // product plus enough headroom that the sum of three never overflows.
    function automatic int res_w(input int n);
        return 2 * n + 3;
    endfunction

endpackage

// File: rtl/sum_prod_mac.sv
// rtl/sum_prod_mac.sv - multiply-accumulate datapath for sum_prod_seq
//
// Optional build macro: SUM_PROD_SEQ_PIPE_EN (registers the product).
// Ports:
//   clk, rst  clock and async active-high reset (pipelined build only)
//   mul_en    capture a*b into the product register (pipelined build only)
//   a, b      N-bit unsigned operands
//   acc_in    RW-bit running sum
//   sum       acc_in + product, RW bits

module sum_prod_mac #(
    parameter int N  = 4,
    parameter int RW = 2 * N + 3
) (
`ifdef SUM_PROD_SEQ_PIPE_EN
    input  logic          clk,
    input  logic          rst,
    input  logic          mul_en,
`endif
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic [RW-1:0] acc_in,
    output logic [RW-1:0] sum
);

    logic [2*N-1:0] prod_c;

    // Operands widened first so the multiply is evaluated at full 2N width.
    assign prod_c = {{N{1'b0}}, a} * {{N{1'b0}}, b};

`ifdef SUM_PROD_SEQ_PIPE_EN
    logic [2*N-1:0] prod_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
        end else if (mul_en) begin
            prod_q <= prod_c;
        end
    end

    assign sum = acc_in + {{(RW-2*N){1'b0}}, prod_q};
`else
    assign sum = acc_in + {{(RW-2*N){1'b0}}, prod_c};
`endif

endmodule

// File: rtl/sum_prod_seq.sv
// rtl/sum_prod_seq.sv - serial X0*X1 + X2*X3 + X4*X5 over valid/ready streams
//
// Optional build macro: SUM_PROD_SEQ_PIPE_EN (extra MUL state per pair).
// Ports:
//   clk, rst    clock and async active-high reset
//   in_valid    in_data holds an operand
//   in_ready    block accepts an operand this cycle (state decode only)
//   in_data     N-bit operand, order X0..X5
//   out_valid   out_result holds a completed result (state decode only)
//   out_ready   consumer accepts the result
//   out_result  2N+3-bit unsigned sum of the three pair products

module sum_prod_seq
    import sum_prod_pkg::*;
#(
    parameter int N         = 4,
    parameter int NUM_PAIRS = NUM_PAIRS_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N+2:0] out_result
);

    localparam int RW = res_w(N);
    localparam int CW = $clog2(NUM_PAIRS + 1);

    state_t         state, state_n;
    logic [N-1:0]   a_reg, a_n;
    logic [RW-1:0]  acc, acc_n;
    logic [RW-1:0]  res_n;
    logic [RW-1:0]  mac_sum;
    logic [CW-1:0]  pair_cnt, cnt_n;
    logic           last_pair;

    assign last_pair = (pair_cnt == CW'(NUM_PAIRS - 1));
    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign out_valid = (state == DONE);

`ifdef SUM_PROD_SEQ_PIPE_EN
    logic mul_en;
    assign mul_en = (state == LOAD_B) && in_valid;

    sum_prod_mac #(.N(N), .RW(RW)) u_mac (
        .clk    (clk),
        .rst    (rst),
        .mul_en (mul_en),
        .a      (a_reg),
        .b      (in_data),
        .acc_in (acc),
        .sum    (mac_sum)
    );
`else
    sum_prod_mac #(.N(N), .RW(RW)) u_mac (
        .a      (a_reg),
        .b      (in_data),
        .acc_in (acc),
        .sum    (mac_sum)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD_A;
            a_reg      <= '0;
            acc        <= '0;
            pair_cnt   <= '0;
            out_result <= '0;
        end else begin
            state      <= state_n;
            a_reg      <= a_n;
            acc        <= acc_n;
            pair_cnt   <= cnt_n;
            out_result <= res_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_reg;
        acc_n   = acc;
        cnt_n   = pair_cnt;
        res_n   = out_result;
        case (state)
            LOAD_A: begin
                if (in_valid) begin
                    a_n     = in_data;
                    state_n = LOAD_B;
                end
            end
`ifdef SUM_PROD_SEQ_PIPE_EN
            // Product is captured on this transfer; accumulate in MUL.
            LOAD_B: begin
                if (in_valid) begin
                    state_n = MUL;
                end
            end
            MUL: begin
                if (last_pair) begin
                    res_n   = mac_sum;
                    state_n = DONE;
                end else begin
                    acc_n   = mac_sum;
                    cnt_n   = pair_cnt + 1'b1;
                    state_n = LOAD_A;
                end
            end
`else
            LOAD_B: begin
                if (in_valid) begin
                    if (last_pair) begin
                        res_n   = mac_sum;
                        state_n = DONE;
                    end else begin
                        acc_n   = mac_sum;
                        cnt_n   = pair_cnt + 1'b1;
                        state_n = LOAD_A;
                    end
                end
            end
`endif
            // out_result is left untouched so it stays readable after the
            // handshake until the next frame completes.
            DONE: begin
                if (out_ready) begin
                    acc_n   = '0;
                    cnt_n   = '0;
                    state_n = LOAD_A;
                end
            end
            default: begin
                state_n = LOAD_A;
            end
        endcase
    end

endmodule

// File: tb/tb_sum_prod_seq.sv
// tb/tb_sum_prod_seq.sv - self-checking bench for sum_prod_seq

module tb_sum_prod_seq;

`ifdef SUM_PROD_SEQ_PIPE_EN
    localparam int LAT  = 2;
    localparam bit PIPE = 1'b1;
`else
    localparam int LAT  = 1;
    localparam bit PIPE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  in_data;
    logic [10:0] out_result;

    logic        d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready;
    logic [7:0]  d8_in_data;
    logic [18:0] d8_out_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sum_prod_seq #(.N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    sum_prod_seq #(.N(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (d8_in_valid),
        .in_ready   (d8_in_ready),
        .in_data    (d8_in_data),
        .out_valid  (d8_out_valid),
        .out_ready  (d8_out_ready),
        .out_result (d8_out_result)
    );

    typedef struct {
        logic [5:0][3:0] x;
        logic [10:0]     exp;
        bit              gaps;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input int a0, input int a1, input int a2,
                                input int a3, input int a4, input int a5,
                                input int e, input bit g);
        vec_t v;
        v.x[0] = 4'(a0); v.x[1] = 4'(a1); v.x[2] = 4'(a2);
        v.x[3] = 4'(a3); v.x[4] = 4'(a4); v.x[5] = 4'(a5);
        v.exp  = 11'(e);
        v.gaps = g;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [3:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
    endtask

    // Called at the negedge right after the X5 transfer edge.
    task automatic wait_result(input string nm, input logic [10:0] exp);
        int n;
        n = 1;
        while (!out_valid && n < 20) begin
            if (PIPE) chk({nm, "_mul_ready"}, 32'(in_ready), 0);
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, LAT);
        chk({nm, "_result"}, 32'(out_result), 32'(exp));
        chk({nm, "_done_ready"}, 32'(in_ready), 0);
        if (out_ready) begin
            @(negedge clk);
            chk({nm, "_valid_drop"}, 32'(out_valid), 0);
            chk({nm, "_retain"}, 32'(out_result), 32'(exp));
        end
    endtask

    task automatic run_frame(input string nm, input vec_t v);
        for (int i = 0; i < 6; i++) begin
            send(v.x[i]);
            if (v.gaps && i < 5) begin
                for (int g = 0; g < (i % 3) + 1; g++) begin
                    if (!PIPE || (i % 2) == 0)
                        chk({nm, "_gap_ready"}, 32'(in_ready), 1);
                    @(negedge clk);
                end
            end
        end
        wait_result(nm, v.exp);
    endtask

    initial begin
        int n;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 4'd0;
        out_ready    = 1'b1;
        d8_in_valid  = 1'b0;
        d8_in_data   = 8'd0;
        d8_out_ready = 1'b1;

        vecs[0] = mk(2, 3, 1, 4, 0, 5, 10, 1'b0);
        vecs[1] = mk(7, 8, 2, 3, 1, 1, 63, 1'b1);
        vecs[2] = mk(15, 15, 15, 15, 15, 15, 675, 1'b0);
        vecs[3] = mk(1, 1, 1, 1, 1, 1, 3, 1'b0);
        vecs[4] = mk(15, 0, 0, 15, 15, 1, 15, 1'b1);
        vecs[5] = mk(0, 9, 6, 7, 3, 13, 81, 1'b0);

        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 1);
        chk("reset_out_valid", 32'(out_valid), 0);
        chk("reset_out_result", 32'(out_result), 0);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back frames with out_ready held high.
        for (int k = 0; k < 6; k++) begin
            run_frame($sformatf("vec%0d", k), vecs[k]);
        end

        // Output stall: result frozen, offered operands not consumed.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(4'd15);
        wait_result("stall", 11'd675);
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 4'd9;
            @(negedge clk);
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_result", 32'(out_result), 675);
            chk("stall_in_ready", 32'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_valid", 32'(out_valid), 0);
        chk("stall_release_retain", 32'(out_result), 675);
        run_frame("after_stall", vecs[0]);

        // Reset mid-frame discards the partial operands.
        send(4'd7);
        send(4'd8);
        send(4'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        run_frame("after_rst", vecs[0]);

        // N=8 instance, all-ones operands.
        for (int i = 0; i < 6; i++) begin
            d8_in_valid = 1'b1;
            d8_in_data  = 8'd255;
            n = 0;
            while (!d8_in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) chk("n8_send_timeout", 0, 1);
            @(negedge clk);
        end
        d8_in_valid = 1'b0;
        n = 1;
        while (!d8_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("n8_latency", n, LAT);
        chk("n8_result", 32'(d8_out_result), 195075);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
